bus_packer: RTL and testbench

//  Generalised video bus width multiplier: packs RATIO consecutive in_den-qualified

---
 rtl/bus_packer.sv | 87 ++++++++
 tb/tb_bus_packer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_packer.sv
// Packs RATIO den-qualified pixels into one wide word (partial groups flushed with PAD_VALUE + keep mask).
// Latency: 1 clock from last/flush input to out_den; syncs delayed 1 clock; no backpressure, consumer takes every word.
module bus_packer #(
    parameter int                  IN_WIDTH  = 8,
    parameter int                  RATIO     = 2,
    parameter int                  LSB_FIRST = 1,
    parameter logic [IN_WIDTH-1:0] PAD_VALUE = '0
) (
    input  logic                      in_clk,
    input  logic                      rst_n,
    input  logic                      in_hsync,
    input  logic                      in_vsync,
    input  logic                      in_den,
    input  logic [IN_WIDTH-1:0]       in_data,
    output logic                      out_hsync,
    output logic                      out_vsync,
    output logic                      out_den,
    output logic [IN_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]          out_keep
);

    localparam int                  CNT_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int                  OUT_W    = IN_WIDTH * RATIO;
    localparam logic [CNT_W-1:0]    LAST     = CNT_W'(RATIO - 1);
    localparam logic [OUT_W-1:0]    PAD_WORD = {RATIO{PAD_VALUE}};

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lane;
    logic [OUT_W-1:0] acc_data;
    logic [OUT_W-1:0] merged_data;
    logic [RATIO-1:0] acc_keep;
    logic [RATIO-1:0] merged_keep;

    // Accumulator with the current pixel dropped into its lane; used both for
    // storing mid-group and for emitting the completed word in the same edge.
    always_comb begin
        lane        = (LSB_FIRST != 0) ? cnt : (LAST - cnt);
        merged_data = acc_data;
        merged_keep = acc_keep;
        for (int i = 0; i < RATIO; i++) begin
            if (CNT_W'(i) == lane) begin
                merged_data[i*IN_WIDTH +: IN_WIDTH] = in_data;
                merged_keep[i]                      = 1'b1;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (!rst_n) begin
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
            out_den   <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            cnt       <= '0;
            acc_data  <= PAD_WORD;
            acc_keep  <= '0;
        end else begin
            out_hsync <= in_hsync;
            out_vsync <= in_vsync;
            out_den   <= 1'b0;
            if (in_den) begin
                if (cnt == LAST) begin
                    out_den  <= 1'b1;
                    out_data <= merged_data;
                    out_keep <= '1;
                    cnt      <= '0;
                    acc_data <= PAD_WORD;
                    acc_keep <= '0;
                end else begin
                    acc_data <= merged_data;
                    acc_keep <= merged_keep;
                    cnt      <= cnt + 1'b1;
                end
            end else if (cnt != '0) begin
                // den dropped mid-group: flush what we have, unfilled lanes already padded
                out_den  <= 1'b1;
                out_data <= acc_data;
                out_keep <= acc_keep;
                cnt      <= '0;
                acc_data <= PAD_WORD;
                acc_keep <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_packer.sv
// Bench for bus_packer: two configurations driven in parallel, checked every cycle
// against a queue-based group model plus literal expected word lists.
module tb_bus_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, hs, vs, den;
    logic [7:0] data;

    logic        o0_hs, o0_vs, o0_den;
    logic [15:0] o0_data;
    logic [1:0]  o0_keep;
    logic        o1_hs, o1_vs, o1_den;
    logic [31:0] o1_data;
    logic [3:0]  o1_keep;

    bus_packer #(.IN_WIDTH(8), .RATIO(2), .LSB_FIRST(1), .PAD_VALUE(8'h00)) u0 (
        .in_clk(clk), .rst_n(rst_n), .in_hsync(hs), .in_vsync(vs), .in_den(den), .in_data(data),
        .out_hsync(o0_hs), .out_vsync(o0_vs), .out_den(o0_den), .out_data(o0_data), .out_keep(o0_keep)
    );

    bus_packer #(.IN_WIDTH(8), .RATIO(4), .LSB_FIRST(0), .PAD_VALUE(8'hFF)) u1 (
        .in_clk(clk), .rst_n(rst_n), .in_hsync(hs), .in_vsync(vs), .in_den(den), .in_data(data),
        .out_hsync(o1_hs), .out_vsync(o1_vs), .out_den(o1_den), .out_data(o1_data), .out_keep(o1_keep)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int ratio_of(input int j);
        return (j == 0) ? 2 : 4;
    endfunction
    function automatic bit lsb_of(input int j);
        return (j == 0);
    endfunction
    function automatic logic [7:0] pad_of(input int j);
        return (j == 0) ? 8'h00 : 8'hFF;
    endfunction

    // Model: each instance collects the pixels of the open group in a list;
    // a word is formed from that list when it reaches RATIO or den drops.
    logic [7:0]  grp [2][8];
    int          gn [2];
    logic        e_den [2];
    logic [63:0] e_data [2];
    logic [7:0]  e_keep [2];
    logic        e_hs, e_vs;
    bit          mvalid = 1'b0;

    task automatic emit(input int j);
        logic [63:0] w;
        logic [7:0]  k;
        int          ln;
        w = '0;
        k = '0;
        for (int l = 0; l < ratio_of(j); l++) w[l*8 +: 8] = pad_of(j);
        for (int p = 0; p < gn[j]; p++) begin
            ln = lsb_of(j) ? p : ratio_of(j) - 1 - p;
            w[ln*8 +: 8] = grp[j][p];
            k[ln]        = 1'b1;
        end
        e_den[j]  = 1'b1;
        e_data[j] = w;
        e_keep[j] = k;
        gn[j]     = 0;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            e_hs = 1'b0;
            e_vs = 1'b0;
            for (int j = 0; j < 2; j++) begin
                gn[j] = 0; e_den[j] = 1'b0; e_data[j] = '0; e_keep[j] = '0;
            end
        end else begin
            e_hs = hs;
            e_vs = vs;
            for (int j = 0; j < 2; j++) begin
                e_den[j] = 1'b0;
                if (den) begin
                    grp[j][gn[j]] = data;
                    gn[j]++;
                    if (gn[j] == ratio_of(j)) emit(j);
                end else if (gn[j] > 0) begin
                    emit(j);
                end
            end
        end
        mvalid = 1'b1;
    end

    logic [63:0] log0_d[$];
    logic [7:0]  log0_k[$];
    logic [63:0] log1_d[$];
    logic [7:0]  log1_k[$];
    int          consec0 = 0;
    logic        prev0   = 1'b0;

    always @(negedge clk) begin
        if (mvalid) begin
            chk("hsync0", o0_hs,   e_hs);
            chk("vsync0", o0_vs,   e_vs);
            chk("den0",   o0_den,  e_den[0]);
            chk("data0",  o0_data, e_data[0][15:0]);
            chk("keep0",  o0_keep, e_keep[0][1:0]);
            chk("hsync1", o1_hs,   e_hs);
            chk("vsync1", o1_vs,   e_vs);
            chk("den1",   o1_den,  e_den[1]);
            chk("data1",  o1_data, e_data[1][31:0]);
            chk("keep1",  o1_keep, e_keep[1][3:0]);
            if (o0_den === 1'b1) begin
                log0_d.push_back({48'h0, o0_data});
                log0_k.push_back({6'h0, o0_keep});
                if (prev0) consec0++;
            end
            if (o1_den === 1'b1) begin
                log1_d.push_back({32'h0, o1_data});
                log1_k.push_back({4'h0, o1_keep});
            end
            prev0 = (o0_den === 1'b1);
        end
    end

    task automatic cyc(input logic r, input logic h, input logic v, input logic d, input logic [7:0] x);
        @(negedge clk);
        rst_n = r; hs = h; vs = v; den = d; data = x;
    endtask

    logic [63:0] x0_d [8] = '{64'ha108, 64'h53a1, 64'h0010, 64'h3312,
                              64'h2211, 64'h4433, 64'h2211, 64'h0033};
    logic [7:0]  x0_k [8] = '{8'h3, 8'h3, 8'h1, 8'h3, 8'h3, 8'h3, 8'h3, 8'h1};
    logic [63:0] x1_d [5] = '{64'h08a1ffff, 64'ha15310ff, 64'h1233ffff,
                              64'h11223344, 64'h112233ff};
    logic [7:0]  x1_k [5] = '{8'hc, 8'he, 8'hc, 8'hf, 8'he};

    initial begin
        rst_n = 1'b0; hs = 1'b0; vs = 1'b0; den = 1'b1; data = 8'hFF;
        // reset held two clocks with den high
        cyc(0, 0, 0, 1, 8'hFF);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        // two-pixel group
        cyc(1, 0, 0, 1, 8'h08);
        cyc(1, 0, 0, 1, 8'ha1);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        // full group then partial flush, hsync rising on the flush cycle
        cyc(1, 0, 0, 1, 8'ha1);
        cyc(1, 0, 0, 1, 8'h53);
        cyc(1, 0, 0, 1, 8'h10);
        cyc(1, 1, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        // sync pattern without data
        cyc(1, 0, 1, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        // reset mid-group drops 8'h75
        cyc(1, 0, 0, 1, 8'h75);
        cyc(0, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 1, 8'h12);
        cyc(1, 0, 0, 1, 8'h33);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        // four-pixel group then three-pixel partial
        cyc(1, 0, 0, 1, 8'h11);
        cyc(1, 0, 0, 1, 8'h22);
        cyc(1, 0, 0, 1, 8'h33);
        cyc(1, 0, 0, 1, 8'h44);
        cyc(1, 0, 0, 1, 8'h11);
        cyc(1, 0, 0, 1, 8'h22);
        cyc(1, 0, 0, 1, 8'h33);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        @(negedge clk);
        @(posedge clk);
        #1;

        chk("words0_count", 64'(log0_d.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < log0_d.size()) begin
                chk($sformatf("word0_%0d_data", i), log0_d[i], x0_d[i]);
                chk($sformatf("word0_%0d_keep", i), 64'(log0_k[i]), 64'(x0_k[i]));
            end
        end
        chk("words1_count", 64'(log1_d.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < log1_d.size()) begin
                chk($sformatf("word1_%0d_data", i), log1_d[i], x1_d[i]);
                chk($sformatf("word1_%0d_keep", i), 64'(log1_k[i]), 64'(x1_k[i]));
            end
        end
        chk("den0_back_to_back", 64'(consec0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
